// File: rtl/event_packetizer.sv
// Event packetizer: captures arbiter grants as {timestamp, y, x} events into a show-ahead FIFO.
// Optional timestamp counter enabled by defining EVT_TIMESTAMP_EN; otherwise the TS field reads 0.
module event_packetizer #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned TS_W       = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         active_i,
    input  logic [ADDR_W-1:0]            x_add_i,
    input  logic [ADDR_W-1:0]            y_add_i,
    output logic                         ack_o,
    output logic                         evt_valid_o,
    input  logic                         evt_ready_i,
    output logic [2*ADDR_W+TS_W-1:0]     evt_data_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
    output logic                         stall_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned EVT_W = 2*ADDR_W + TS_W;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        HOLD
    } state_e;

    state_e              state_q;
    logic                ack_q;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [EVT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [TS_W-1:0]     ts_val;
    logic                full, push, pop;

`ifdef EVT_TIMESTAMP_EN
    logic [TS_W-1:0]     ts_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign ts_val = ts_q;
`else
    assign ts_val = '0;
`endif

    // Full check uses the registered count, so a same-cycle pop never frees a slot early.
    assign full         = (count_q == CNT_W'(FIFO_DEPTH));
    assign push         = (state_q == IDLE) && active_i && !full;
    assign pop          = evt_valid_o && evt_ready_i;
    assign evt_valid_o  = (count_q != '0);
    assign stall_o      = (state_q == IDLE) && active_i && full;
    assign fifo_count_o = count_q;
    assign ack_o        = ack_q;
    assign evt_data_o   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            mem_q[wr_ptr_q] <= {ts_val, y_add_i, x_add_i};
        end
    end

    // One grant yields one event: after capture, wait for the grant to drop before re-arming.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                    end
                end
                ACK: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!active_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_packetizer.sv
// Scoreboard bench for event_packetizer: stimulus predicts events into a queue, a monitor checks them.
// Honours EVT_TIMESTAMP_EN the same way as the design (TS field expected 0 when undefined).
module tb_event_packetizer;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned TS_W   = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned EVT_W  = 2*ADDR_W + TS_W;

    logic                      clk = 1'b0;
    logic                      reset_i = 1'b1;
    logic                      active_i = 1'b0;
    logic                      evt_ready_i = 1'b0;
    logic [ADDR_W-1:0]         x_add_i = '0;
    logic [ADDR_W-1:0]         y_add_i = '0;
    logic                      ack_o, evt_valid_o, stall_o;
    logic [EVT_W-1:0]          evt_data_o;
    logic [$clog2(DEPTH):0]    fifo_count_o;

    event_packetizer #(
        .ADDR_W     (ADDR_W),
        .TS_W       (TS_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .active_i     (active_i),
        .x_add_i      (x_add_i),
        .y_add_i      (y_add_i),
        .ack_o        (ack_o),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_data_o   (evt_data_o),
        .fifo_count_o (fifo_count_o),
        .stall_o      (stall_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: expected events in order, buffered occupancy, grant bookkeeping by edge number.
    logic [EVT_W-1:0] sb[$];
    int  mcnt     = 0;
    bit  released = 1'b1;
    int  cap_edge = -10;
    int  edge_n   = 0;
    int  cyc      = 0;
    bit  exp_ack  = 1'b0;
    bit  mon_en   = 1'b0;

    logic [ADDR_W-1:0] xv, yv;
    bit                act;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive inputs for the next edge, predict its effect, then commit the prediction after the edge.
    task automatic step(input bit rst, input bit a, input logic [ADDR_W-1:0] x,
                        input logic [ADDR_W-1:0] y, input bit rdy);
        bit             do_push, do_pop;
        logic [TS_W-1:0] ts;
        reset_i     = rst;
        active_i    = a;
        x_add_i     = x;
        y_add_i     = y;
        evt_ready_i = rdy;
        do_pop  = !rst && (mcnt != 0) && rdy;
        do_push = !rst && released && a && (mcnt < DEPTH);
`ifdef EVT_TIMESTAMP_EN
        ts = TS_W'(cyc % (1 << TS_W));
`else
        ts = '0;
`endif
        if (do_push) sb.push_back({ts, y, x});
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            mcnt     = 0;
            released = 1'b1;
            cap_edge = -10;
            cyc      = 0;
            exp_ack  = 1'b0;
            mon_en   = 1'b1;
        end else begin
            exp_ack = do_push;
            mcnt    = mcnt + int'(do_push) - int'(do_pop);
            if (do_push) begin
                released = 1'b0;
                cap_edge = edge_n;
            end else if (!released && !a && edge_n >= cap_edge + 2) begin
                released = 1'b1;
            end
            cyc++;
        end
        edge_n++;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("count", 64'(fifo_count_o), 64'(mcnt));
            check("valid", 64'(evt_valid_o), 64'(mcnt != 0));
            check("ack",   64'(ack_o), 64'(exp_ack));
            check("stall", 64'(stall_o), 64'(released && active_i && (mcnt == DEPTH)));
            if (evt_valid_o && evt_ready_i && !reset_i) begin
                if (sb.size() == 0) begin
                    check("data_unexpected", 64'(evt_data_o), 64'hDEAD_0000_0000);
                end else begin
                    check("data", 64'(evt_data_o), 64'(sb.pop_front()));
                end
            end
        end
    end

    task automatic grant(input logic [ADDR_W-1:0] x, input logic [ADDR_W-1:0] y, input int hold);
        repeat (hold) step(0, 1, x, y, 0);
        step(0, 0, x, y, 0);
    endtask

    task automatic drain(input int n);
        repeat (n) step(0, 0, '0, '0, 1);
    endtask

    initial begin
        step(1, 0, '0, '0, 0);
        step(1, 0, '0, '0, 0);

        // Single grant held for four cycles: exactly one event and one ack.
        grant(4'd3, 4'd5, 4);
        check("single_count", 64'(fifo_count_o), 64'd1);
        drain(3);

        // Fill to depth, then a ninth grant stalls until a pop frees a slot.
        for (int g = 0; g < 8; g++) begin
            grant(ADDR_W'($urandom), ADDR_W'($urandom), 3);
        end
        check("full_count", 64'(fifo_count_o), 64'(DEPTH));
        xv = ADDR_W'($urandom);
        yv = ADDR_W'($urandom);
        repeat (4) step(0, 1, xv, yv, 0);
        step(0, 1, xv, yv, 1);
        repeat (3) step(0, 1, xv, yv, 0);
        step(0, 0, xv, yv, 0);
        check("refill_count", 64'(fifo_count_o), 64'(DEPTH));
        drain(12);

        // Randomised grants and back-pressure.
        act = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!act) begin
                if ($urandom_range(0, 2) == 0) begin
                    act = 1'b1;
                    xv  = ADDR_W'($urandom);
                    yv  = ADDR_W'($urandom);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                act = 1'b0;
            end
            step(0, act, xv, yv, $urandom_range(0, 2) == 0);
        end
        step(0, 0, xv, yv, 0);
        drain(12);

        // Reset while holding a grant with three buffered events; the held grant is re-captured.
        grant(4'd7, 4'd1, 3);
        grant(4'd2, 4'd9, 3);
        repeat (3) step(0, 1, 4'd4, 4'd4, 0);
        check("pre_rst_count", 64'(fifo_count_o), 64'd3);
        step(1, 1, 4'd4, 4'd4, 0);
        check("rst_count", 64'(fifo_count_o), 64'd0);
        check("rst_valid", 64'(evt_valid_o), 64'd0);
        check("rst_ack",   64'(ack_o), 64'd0);
        grant(4'd4, 4'd4, 3);
        check("post_rst_count", 64'(fifo_count_o), 64'd1);
        drain(3);

        // Timestamp wrap: idle past 2^16 cycles from reset, then capture x=1, y=2.
        step(1, 0, '0, '0, 0);
        repeat (65540) step(0, 0, '0, '0, 0);
        grant(4'd1, 4'd2, 4);
        drain(3);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
